// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 16-bit ISA words and
// streams them, with sequential memory addresses, toward instruction memory.
// Range-checks fields, stops on END, and latches error/done status until start.
module instr_encoder #(
  parameter int MEMO_LINES = 64,
  parameter int REGI_SIZE  = 16,
  localparam int ADDR_W    = $clog2(MEMO_LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [1:0]            in_cond,
  input  logic [3:0]            in_ra,
  input  logic [3:0]            in_rb,
  input  logic [3:0]            in_rd,
  input  logic [1:0]            in_va,
  input  logic [1:0]            in_vd,
  input  logic [9:0]            in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REGI_SIZE-1:0]  out_word,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [ADDR_W:0]       count,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [3:0] OP_END = 4'd14;

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [REGI_SIZE-1:0]  out_word_q, out_word_d;
  logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  held_end_q, held_end_d;

  logic [REGI_SIZE-1:0]  enc_word;
  logic [1:0]            enc_code;
  logic                  last_addr;
  logic                  out_fire;
  logic                  accept;

  // Field packing and range checking for the bundle currently on the inputs
  always_comb begin
    enc_word      = '0;
    enc_code      = 2'd0;
    enc_word[3:0] = in_opcode;
    case (in_opcode)
      4'd0: begin
        enc_word[13:10] = in_ra;
        enc_word[9:6]   = in_rb;
      end
      4'd1: begin
        enc_word[15:14] = in_cond;
        enc_word[13:4]  = in_imm;
        if ({1'b0, in_imm} >= 11'(MEMO_LINES)) enc_code = 2'd2;
      end
      4'd2, 4'd6, 4'd7: begin
        enc_word[15:14] = in_cond;
        enc_word[12:11] = in_va;
        enc_word[10:9]  = in_vd;
        enc_word[8:5]   = in_rb;
      end
      4'd3: begin
        enc_word[15:14] = in_cond;
        enc_word[12:11] = in_va;
        enc_word[10:9]  = in_vd;
        enc_word[8:4]   = in_imm[4:0];
        if (in_imm > 10'd31) enc_code = 2'd2;
      end
      4'd4, 4'd5: begin
        enc_word[15:14] = in_cond;
        enc_word[13:10] = in_ra;
        enc_word[9:8]   = (in_opcode == 4'd4) ? in_vd : in_va;
        enc_word[7:5]   = in_imm[2:0];
        if (in_imm > 10'd7) enc_code = 2'd2;
      end
      4'd8: begin
        enc_word[15:14] = in_cond;
        enc_word[13:12] = in_va;
        enc_word[11:10] = in_vd;
        enc_word[9:7]   = in_imm[5:3];
        enc_word[6:4]   = in_imm[2:0];
        if (in_imm > 10'd63) enc_code = 2'd2;
      end
      4'd9, 4'd10: begin
        enc_word[15:12] = in_ra;
        enc_word[11:8]  = in_rd;
        enc_word[7:4]   = in_rb;
      end
      4'd11, 4'd12: begin
        enc_word[15:12] = in_ra;
        enc_word[11:8]  = in_rd;
        enc_word[7:4]   = in_imm[3:0];
        if (in_imm > 10'd15) enc_code = 2'd2;
      end
      4'd13, 4'd14: ;
      default: enc_code = 2'd1;
    endcase
  end

  assign last_addr = (out_addr_q == ADDR_W'(MEMO_LINES - 1));
  assign out_fire  = out_valid_q && out_ready;
  // A held END or a held word at the last line ends the stream once it drains,
  // so no further bundle is taken alongside it (it would have no valid slot).
  assign in_ready  = (state_q == S_RUN) && !start &&
                     (!out_valid_q || (out_ready && !held_end_q && !last_addr));
  assign accept    = in_valid && in_ready;

  // Next-state, output register and status update
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    count_d     = count_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    held_end_d  = held_end_q;
    if (start) begin
      state_d     = S_RUN;
      out_valid_d = 1'b0;
      out_addr_d  = '0;
      count_d     = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = 2'd0;
      held_end_d  = 1'b0;
    end else if (state_q == S_RUN) begin
      if (out_fire) begin
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q + ADDR_W'(1);
        count_d     = count_q + (ADDR_W+1)'(1);
        if (held_end_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (last_addr) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end
      end
      if (accept) begin
        if (enc_code != 2'd0) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = enc_code;
        end else begin
          out_valid_d = 1'b1;
          out_word_d  = enc_word;
          held_end_d  = (in_opcode == OP_END);
        end
      end
    end
  end

  // State register with asynchronous reset clearing everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      held_end_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      held_end_q  <= held_end_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = out_addr_q;
  assign count     = count_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
